// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: aligns byte lanes, runs a req/gnt/rvalid
// handshake with data memory, stalls the pipeline and extends load data.
module load_store_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    mem_read,
  input  logic [3:0]    mem_write,
  input  logic          mem_sign_extend,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          misalign,
  output logic          bus_req,
  output logic          bus_we,
  output logic [3:0]    bus_be,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_gnt,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_off;
  logic [3:0]    r_mask;
  logic          r_sext;
  logic          r_bus_req;
  logic          r_bus_we;
  logic [3:0]    r_bus_be;
  logic [AW-1:0] r_bus_addr;
  logic [DW-1:0] r_bus_wdata;
  logic [DW-1:0] r_rdata;

  logic          w_op;
  logic          w_bad;
  logic          w_launch;
  logic [3:0]    w_mask;

  function automatic logic mask_ok(input logic [3:0] m, input logic [1:0] a);
    return (m == 4'b0001) ||
           (m == 4'b0011 && !a[0]) ||
           (m == 4'b1111 && a == 2'b00);
  endfunction

  // Bring the addressed lanes down to bit 0, then extend per access size.
  function automatic logic [DW-1:0] extend_load(input logic [DW-1:0] word,
                                                input logic [1:0]    off,
                                                input logic [3:0]    m,
                                                input logic          sext);
    logic [DW-1:0] s;
    s = word >> {off, 3'b000};
    case (m)
      4'b0001: return sext ? {{24{s[7]}}, s[7:0]}   : {24'h0, s[7:0]};
      4'b0011: return sext ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  assign w_op     = (mem_read != 4'b0000) || (mem_write != 4'b0000);
  assign w_mask   = (mem_write != 4'b0000) ? mem_write : mem_read;
  assign w_bad    = w_op && (((mem_read != 4'b0000) && (mem_write != 4'b0000)) ||
                             !mask_ok(w_mask, addr[1:0]));
  assign w_launch = (r_state == S_IDLE) && w_op && !w_bad;

  always_comb begin
    w_next      = r_state;
    stall       = 1'b0;
    misalign    = 1'b0;
    rdata_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        misalign = w_bad;
        stall    = w_launch;
        if (w_launch) w_next = S_REQ;
      end
      S_REQ: begin
        stall = 1'b1;
        if (bus_gnt) w_next = r_bus_we ? S_DONE : S_RESP;
      end
      S_RESP: begin
        stall = 1'b1;
        if (bus_rvalid) w_next = S_DONE;
      end
      S_DONE: begin
        rdata_valid = !r_bus_we;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_off       <= 2'b00;
      r_mask      <= 4'b0000;
      r_sext      <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= 4'b0000;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_off       <= addr[1:0];
            r_mask      <= w_mask;
            r_sext      <= mem_sign_extend;
            r_bus_req   <= 1'b1;
            r_bus_we    <= (mem_write != 4'b0000);
            r_bus_be    <= w_mask << addr[1:0];
            r_bus_addr  <= {addr[AW-1:2], 2'b00};
            r_bus_wdata <= wdata << {addr[1:0], 3'b000};
          end
        end
        S_REQ: begin
          if (bus_gnt) r_bus_req <= 1'b0;
        end
        S_RESP: begin
          if (bus_rvalid) r_rdata <= extend_load(bus_rdata, r_off, r_mask, r_sext);
        end
        default: ;
      endcase
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_be    = r_bus_be;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, extended loads, delayed
// handshakes, misaligned rejects and asynchronous reset mid-access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mem_read;
  logic [3:0]  mem_write;
  logic        mem_sign_extend;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int errs   = 0;
  int checks = 0;
  int nst;

  always #5 clk = ~clk;

  load_store_unit #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_sign_extend(mem_sign_extend),
    .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .misalign(misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] rd, input logic [3:0] wr, input logic se,
                        input logic [31:0] a, input logic [31:0] wd);
    mem_read        = rd;
    mem_write       = wr;
    mem_sign_extend = se;
    addr            = a;
    wdata           = wd;
  endtask

  // Load with gd REQ cycles before gnt and rvalid rd cycles after gnt.
  task automatic do_load(input logic [3:0] m, input logic se, input logic [31:0] a,
                         input logic [31:0] word, input int gd, input int rd,
                         output int n_stall);
    n_stall = 0;
    tick(); set_op(m, 4'h0, se, a, 32'h0); #1;
    n_stall += int'(stall);
    for (int i = 0; i < gd; i++) begin
      tick(); #1;
      n_stall += int'(stall);
      chk("ld_req_hold", bus_req, 1'b1);
      chk("ld_addr_hold", bus_addr, {a[31:2], 2'b00});
    end
    tick(); bus_gnt = 1'b1; #1;
    n_stall += int'(stall);
    chk("ld_req_at_gnt", bus_req, 1'b1);
    chk("ld_we", bus_we, 1'b0);
    for (int i = 1; i <= rd; i++) begin
      tick(); bus_gnt = 1'b0;
      bus_rvalid = (i == rd);
      bus_rdata  = (i == rd) ? word : 32'h0;
      #1;
      n_stall += int'(stall);
    end
    tick(); bus_rvalid = 1'b0; #1;
    n_stall += int'(stall);
    chk("ld_done_valid", rdata_valid, 1'b1);
    chk("ld_done_stall", stall, 1'b0);
    tick(); set_op(4'h0, 4'h0, 1'b0, 32'h0, 32'h0); #1;
    chk("ld_valid_drop", rdata_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    set_op(4'h0, 4'h0, 1'b0, 32'h0, 32'h0);
    #3;
    chk("rst_stall", stall, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", rdata_valid, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_req", bus_req, 1'b0);
    chk("rst_we", bus_we, 1'b0);
    chk("rst_be", bus_be, 4'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    tick(); rst_n = 1'b1;

    // SW 0x104, grant on first request cycle
    tick(); set_op(4'h0, 4'hF, 1'b0, 32'h104, 32'hDEADBEEF); #1;
    chk("sw_c0_stall", stall, 1'b1);
    chk("sw_c0_req", bus_req, 1'b0);
    tick(); bus_gnt = 1'b1; #1;
    chk("sw_c1_stall", stall, 1'b1);
    chk("sw_req", bus_req, 1'b1);
    chk("sw_we", bus_we, 1'b1);
    chk("sw_be", bus_be, 4'hF);
    chk("sw_addr", bus_addr, 32'h104);
    chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
    tick(); bus_gnt = 1'b0; #1;
    chk("sw_done_stall", stall, 1'b0);
    chk("sw_done_rvalid", rdata_valid, 1'b0);
    chk("sw_done_req", bus_req, 1'b0);
    tick(); set_op(4'h0, 4'h0, 1'b0, 32'h0, 32'h0); #1;
    chk("sw_idle_req", bus_req, 1'b0);

    // SB 0x203
    tick(); set_op(4'h0, 4'h1, 1'b0, 32'h203, 32'h000000A5); #1;
    chk("sb_c0_stall", stall, 1'b1);
    tick(); bus_gnt = 1'b1; #1;
    chk("sb_addr", bus_addr, 32'h200);
    chk("sb_be", bus_be, 4'h8);
    chk("sb_wdata", bus_wdata, 32'hA5000000);
    tick(); bus_gnt = 1'b0; #1;
    chk("sb_done_stall", stall, 1'b0);
    tick(); set_op(4'h0, 4'h0, 1'b0, 32'h0, 32'h0); #1;

    // LBS / LB at 0x102 on 0x12F03456
    do_load(4'h1, 1'b1, 32'h102, 32'h12F03456, 0, 1, nst);
    chk("lbs_rdata", rdata, 32'hFFFFFFF0);
    chk("lbs_stall_cycles", nst, 3);
    do_load(4'h1, 1'b0, 32'h102, 32'h12F03456, 0, 1, nst);
    chk("lb_rdata", rdata, 32'h000000F0);

    // LHS 0x102, gnt delayed 3 cycles, rvalid 2 cycles after gnt
    do_load(4'h3, 1'b1, 32'h102, 32'h8001ABCD, 3, 2, nst);
    chk("lhs_rdata", rdata, 32'hFFFF8001);
    chk("lhs_stall_cycles", nst, 7);

    // LW ignores sign flag
    do_load(4'hF, 1'b1, 32'h10, 32'h80000001, 1, 1, nst);
    chk("lw_rdata", rdata, 32'h80000001);

    // Rejected accesses
    tick(); set_op(4'hF, 4'h0, 1'b0, 32'h101, 32'h0); #1;
    chk("lw_mis", misalign, 1'b1);
    chk("lw_mis_stall", stall, 1'b0);
    tick(); set_op(4'h0, 4'h0, 1'b0, 32'h0, 32'h0); #1;
    chk("lw_mis_drop", misalign, 1'b0);
    chk("lw_mis_req", bus_req, 1'b0);
    tick(); set_op(4'h0, 4'h3, 1'b0, 32'h003, 32'h1234); #1;
    chk("sh_mis", misalign, 1'b1);
    chk("sh_mis_stall", stall, 1'b0);
    tick(); set_op(4'h0, 4'h0, 1'b0, 32'h0, 32'h0); #1;
    chk("sh_mis_req", bus_req, 1'b0);
    tick(); set_op(4'h7, 4'h0, 1'b0, 32'h0, 32'h0); #1;
    chk("m0111_mis", misalign, 1'b1);
    tick(); set_op(4'h1, 4'h1, 1'b0, 32'h0, 32'h0); #1;
    chk("both_mis", misalign, 1'b1);
    tick(); set_op(4'h0, 4'h0, 1'b0, 32'h0, 32'h0); #1;
    chk("mis_end_req", bus_req, 1'b0);
    chk("mis_end_pulse", misalign, 1'b0);

    // Reset in RESP, then a late rvalid
    tick(); set_op(4'hF, 4'h0, 1'b0, 32'h100, 32'h0); #1;
    tick(); bus_gnt = 1'b1; #1;
    chk("rr_req", bus_req, 1'b1);
    tick(); bus_gnt = 1'b0; #1;
    chk("rr_resp_stall", stall, 1'b1);
    rst_n = 1'b0;
    set_op(4'h0, 4'h0, 1'b0, 32'h0, 32'h0); #1;
    chk("rr_stall", stall, 1'b0);
    chk("rr_req0", bus_req, 1'b0);
    chk("rr_be0", bus_be, 4'h0);
    chk("rr_addr0", bus_addr, 32'h0);
    tick(); rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D; #1;
    chk("rr_late_valid", rdata_valid, 1'b0);
    tick(); bus_rvalid = 1'b0; #1;
    chk("rr_late_valid2", rdata_valid, 1'b0);
    chk("rr_rdata", rdata, 32'h0);
    tick(); set_op(4'h0, 4'hF, 1'b0, 32'h8, 32'h11223344); #1;
    chk("rr_sw_stall", stall, 1'b1);
    tick(); bus_gnt = 1'b1; #1;
    chk("rr_sw_req", bus_req, 1'b1);
    chk("rr_sw_addr", bus_addr, 32'h8);
    chk("rr_sw_wdata", bus_wdata, 32'h11223344);
    tick(); bus_gnt = 1'b0; #1;
    chk("rr_sw_done", stall, 1'b0);
    tick(); set_op(4'h0, 4'h0, 1'b0, 32'h0, 32'h0); #1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
